// File: rtl/rr_arbiter_1hot.sv
// Round-robin arbiter driving a registered one-hot select for a one-hot mux.
// An all-zero select means no grant. The grant is held under a valid/ready handshake.
// Optional burst lock is built only when RR_ARB_LOCK_EN is defined.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request per requester
//   lock    : keep-grant request, qualified by req (ignored without RR_ARB_LOCK_EN)
//   ready   : consumer accepts the current grant this cycle
//   sel     : registered one-hot grant
//   valid   : registered, equal to |sel
//   gnt_idx : binary index of the sel bit, 0 when there is no grant
module rr_arbiter_1hot #(
    parameter int INPUTS   = 8,
    parameter int MAX_HOLD = 4,
    parameter int IDXW     = $clog2(INPUTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INPUTS-1:0] req,
    input  logic [INPUTS-1:0] lock,
    input  logic              ready,
    output logic [INPUTS-1:0] sel,
    output logic              valid,
    output logic [IDXW-1:0]   gnt_idx
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [INPUTS-1:0] sel_d;
    logic [IDXW-1:0]   idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              win_found;
    logic [IDXW-1:0]   win_idx;

    // The search starts just after ptr, so the last winner is searched last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= INPUTS; k++) begin
            int j;
            j = (int'(ptr_q) + k) % INPUTS;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(j);
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    localparam int HW = $clog2(MAX_HOLD) + 1;

    logic [HW-1:0] hold_q, hold_d;
    logic          keep;

    assign keep = lock[gnt_idx] && req[gnt_idx] &&
                  (hold_q < HW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    logic keep;
    logic unused_lock;

    assign keep        = 1'b0;
    assign unused_lock = ^lock;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        idx_d   = gnt_idx;
        ptr_d   = ptr_q;
`ifdef RR_ARB_LOCK_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d          = '0;
                    sel_d[win_idx] = 1'b1;
                    idx_d          = win_idx;
                    ptr_d          = win_idx;
                    state_d        = GRANT;
`ifdef RR_ARB_LOCK_EN
                    hold_d         = '0;
`endif
                end
            end
            GRANT: begin
                if (ready) begin
                    if (keep) begin
`ifdef RR_ARB_LOCK_EN
                        hold_d = hold_q + 1'b1;
`endif
                    end else if (win_found) begin
                        sel_d          = '0;
                        sel_d[win_idx] = 1'b1;
                        idx_d          = win_idx;
                        ptr_d          = win_idx;
`ifdef RR_ARB_LOCK_EN
                        hold_d         = '0;
`endif
                    end else begin
                        sel_d   = '0;
                        idx_d   = '0;
                        state_d = IDLE;
`ifdef RR_ARB_LOCK_EN
                        hold_d  = '0;
`endif
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel     <= '0;
            valid   <= 1'b0;
            gnt_idx <= '0;
            ptr_q   <= IDXW'(INPUTS - 1);
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            valid   <= |sel_d;
            gnt_idx <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: doc/rr_arbiter_1hot.md
Name: rr_arbiter_1hot

Overview:
- Round-robin arbiter that produces the registered one-hot select vector consumed by a one-hot mux with default output.
- All-zero select means "no grant"; the downstream mux then outputs its default.
- Grant is held stable under a valid/ready handshake.
- Optional burst lock lets a requester keep the grant for up to MAX_HOLD consecutive transfers.

Parameters:
- INPUTS, 8, number of requesters; width of req/lock/sel; must be >= 2.
- MAX_HOLD, 4, max consecutive accepted transfers for one locked requester; must be >= 1.
- IDXW, $clog2(INPUTS), width of gnt_idx (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  INPUTS  request per requester; bit i = requester i.
- lock  input  INPUTS  requester i asks to keep the grant after acceptance; qualified by req[i].
- ready  input  1  downstream consumer accepts the current grant this cycle.
- sel  output  INPUTS  registered one-hot grant; all-zero = no grant.
- valid  output  1  registered; equals |sel.
- gnt_idx  output  IDXW  binary index of the set sel bit; 0 when sel == 0.

Behaviour:
- Reset (rst_n low, async): sel=0, valid=0, gnt_idx=0, hold_cnt=0, ptr=INPUTS-1, state=IDLE. Effect: requester 0 has top priority after reset.
- Search order from ptr: ptr+1, ptr+2, ..., wrapping modulo INPUTS, ending at ptr itself. The first set req bit in this order wins.
- States: IDLE (sel==0) and GRANT (sel!=0).
- IDLE:
  - If req != 0, the winner is registered into sel next edge; latency is 1 cycle from req to sel.
  - ptr <= winner; hold_cnt <= 0; state <= GRANT.
  - If req == 0, stay in IDLE.
- GRANT, ready=0: sel, gnt_idx, hold_cnt and ptr hold unchanged. The grant is never retracted, even if req[gnt] deasserts.
- GRANT, ready=1 (transfer accepted), in priority order:
  - Keep: if lock[gnt] && req[gnt] && hold_cnt < MAX_HOLD-1, then sel unchanged and hold_cnt++.
  - Re-arbitrate: else if req has any bit set, search from ptr=gnt and register the winner with no idle bubble. The current holder is searched last, so it wins only if it is the sole requester. hold_cnt <= 0.
  - Release: else (req == 0), sel <= 0 and state <= IDLE.
- Winner uses req sampled in the same cycle as the ready/IDLE decision. No combinational path from req or ready to sel.
- Invariants: sel always zero or exactly one-hot; valid == |sel; gnt_idx == index(sel).
- hold_cnt width: $clog2(MAX_HOLD)+1. It saturates at MAX_HOLD-1 by construction.
- With MAX_HOLD=1, lock has no effect.
- Async reset mid-grant clears sel immediately; the consumer sees the default path.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined: lock and hold_cnt behave as above.
- Undefined:
  - The lock port is still present but ignored.
  - The hold_cnt register is not built.
  - Every ready=1 in GRANT takes the re-arbitrate or release branch (pure round-robin).

Test Plan:
- Reset then req=8'h00 for 5 cycles -> sel=0, valid=0, gnt_idx=0 throughout.
- req=8'hFF, ready=1 every cycle, no lock -> sel sequence 01,02,04,...,80,01; each requester granted once per 8 cycles, no bubbles.
- req=8'h24, ready=0 for 3 cycles, then ready=1 -> sel=04 held for all 4 cycles, then sel=20 on the next edge.
- Grant held when the request drops: req=8'h01 then req=8'h00 with ready=0 -> sel stays 01, valid=1. Then ready=1 -> sel=00 next edge, default path selected.
- Lock burst (RR_ARB_LOCK_EN, MAX_HOLD=4): req=8'h03, lock=8'h01, ready=1 -> sel=01 for 4 accepted transfers, then 02; without the macro, sel alternates 01,02,01,02.
- Async reset mid-grant: rst_n low while sel=10 -> sel=0 without waiting for a clock edge. After release with req=8'h11 -> first grant sel=01 (ptr back to 7).
